bitty_core_param: RTL and testbench



---
 rtl/bitty_pkg.sv | 12 +
 rtl/bitty_core_param_if.sv | 11 +
 rtl/bitty_alu.sv | 31 +++
 rtl/bitty_core_param.sv | 101 ++++++++++
 tb/tb_bitty_core_param.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitty_pkg.sv
// bitty_pkg: shared FSM states, ALU op codes, format codes and instruction field positions
package bitty_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXEC, ST_WB} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_CMP} alu_op_t;
  localparam logic [1:0] FMT_REG = 2'b00;
  localparam logic [1:0] FMT_IMM = 2'b01;
  localparam int RX_LO  = 13;
  localparam int RY_LO  = 10;
  localparam int IMM_LO = 5;
  localparam int OP_LO  = 2;
  localparam int FMT_LO = 0;
endpackage

// File: rtl/bitty_core_param_if.sv
// bitty_core_param_if: instruction intake handshake plus retirement pulses
// Signals: inst_valid/instruction (source -> core), inst_ready/done/illegal (core -> source).
interface bitty_core_param_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] instruction;
  logic        done;
  logic        illegal;
  modport master (output inst_valid, instruction, input inst_ready, done, illegal);
  modport slave  (input inst_valid, instruction, output inst_ready, done, illegal);
endinterface

// File: rtl/bitty_alu.sv
// bitty_alu: combinational 8-op ALU (add/sub/and/or/xor/shl/shr/unsigned cmp)
// Ports: i_a (operand A), i_b (operand B), i_op (operation), o_y (result).
module bitty_alu
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_t           i_op,
  output logic [DATA_W-1:0] o_y
);
  localparam int SH_W = $clog2(DATA_W);
  logic [SH_W-1:0]   w_sh;
  logic [DATA_W-1:0] w_cmp;
  assign w_sh  = i_b[SH_W-1:0];
  assign w_cmp = (i_a == i_b) ? '0 : (i_a > i_b) ? DATA_W'(1) : DATA_W'(2);
  always_comb begin
    o_y = w_cmp;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_SHL:  o_y = i_a << w_sh;
      OP_SHR:  o_y = i_a >> w_sh;
      default: o_y = w_cmp;
    endcase
  end
endmodule

// File: rtl/bitty_core_param.sv
// bitty_core_param: parametrised 4-state Bitty execution core with valid/ready intake
// Ports: clk; reset (async, active-low); bus (slave: inst_valid/instruction in,
//   inst_ready/done/illegal out); reg_inst_out, reg_s_out, reg_c_out; reg_file_out (R0 in LSBs).
// Build option: define BITTY_IMM_EN to make format 01 an 8-bit zero-extended immediate.
module bitty_core_param
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  bitty_core_param_if.slave       bus,
  output logic [15:0]             reg_inst_out,
  output logic [DATA_W-1:0]       reg_s_out,
  output logic [DATA_W-1:0]       reg_c_out,
  output logic [NREGS*DATA_W-1:0] reg_file_out
);
  if (NREGS != 8) begin : g_bad_nregs
    $error("bitty_core_param: NREGS must be 8 (3-bit register fields)");
  end
  if (DATA_W < 8 || DATA_W > 64) begin : g_bad_width
    $error("bitty_core_param: DATA_W must be within 8..64");
  end
  state_t            r_state;
  logic [15:0]       r_inst;
  logic [DATA_W-1:0] r_s;
  logic [DATA_W-1:0] r_c;
  logic [DATA_W-1:0] r_rf [NREGS];
  logic              r_done;
  logic              r_illegal;
  logic [2:0]        w_rx;
  logic [2:0]        w_ry;
  logic [1:0]        w_fmt;
  alu_op_t           w_op;
  logic              w_imm;
  logic              w_legal;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;
  assign w_rx  = r_inst[RX_LO +: 3];
  assign w_ry  = r_inst[RY_LO +: 3];
  assign w_fmt = r_inst[FMT_LO +: 2];
  assign w_op  = alu_op_t'(r_inst[OP_LO +: 3]);
`ifdef BITTY_IMM_EN
  assign w_imm = (w_fmt == FMT_IMM);
`else
  assign w_imm = 1'b0;
`endif
  assign w_legal = (w_fmt == FMT_REG) || w_imm;
  assign w_b     = w_imm ? DATA_W'(r_inst[IMM_LO +: 8]) : r_rf[w_ry];
  bitty_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a  (r_s),
    .i_b  (w_b),
    .i_op (w_op),
    .o_y  (w_alu)
  );
  // Illegal formats still walk LOAD/EXEC so S and C update; only the write-back is suppressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_inst    <= '0;
      r_s       <= '0;
      r_c       <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: if (bus.inst_valid) begin
          r_inst  <= bus.instruction;
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_s     <= r_rf[w_rx];
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_c     <= w_alu;
          r_state <= ST_WB;
        end
        default: begin
          if (w_legal) r_rf[w_rx] <= r_c;
          r_done    <= 1'b1;
          r_illegal <= !w_legal;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end
  assign bus.inst_ready = (r_state == ST_IDLE);
  assign bus.done       = r_done;
  assign bus.illegal    = r_illegal;
  assign reg_inst_out   = r_inst;
  assign reg_s_out      = r_s;
  assign reg_c_out      = r_c;
  for (genvar g = 0; g < NREGS; g++) begin : g_rf
    assign reg_file_out[g*DATA_W +: DATA_W] = r_rf[g];
  end
endmodule

// File: tb/tb_bitty_core_param.sv
// tb_bitty_core_param: randomized scoreboard bench for bitty_core_param against a behavioural model
module tb_bitty_core_param;
  import bitty_pkg::*;
  localparam int DW = 16;
`ifdef BITTY_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif
  typedef logic [8*DW-1:0] wide_t;
  typedef struct {
    wide_t          rf;
    logic [DW-1:0]  c;
    logic           ill;
    int             acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   reg_inst_out;
  logic [DW-1:0] reg_s_out;
  logic [DW-1:0] reg_c_out;
  wide_t         reg_file_out;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            last_acc = 0;
  logic [DW-1:0] m_rf [8];
  exp_t          sbq [$];
  exp_t          mon_e;

  bitty_core_param_if bif ();

  bitty_core_param #(.DATA_W(DW), .NREGS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bif),
    .reg_inst_out (reg_inst_out),
    .reg_s_out    (reg_s_out),
    .reg_c_out    (reg_c_out),
    .reg_file_out (reg_file_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << (b % DW);
      3'd6:    return a >> (b % DW);
      default: return (a == b) ? DW'(0) : (a > b) ? DW'(1) : DW'(2);
    endcase
  endfunction

  function automatic wide_t flat();
    wide_t r;
    for (int i = 0; i < 8; i++) r[i*DW +: DW] = m_rf[i];
    return r;
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] op, input logic [1:0] fmt);
    return {rx, ry, 5'b0, op, fmt};
  endfunction

  function automatic wide_t reg_of(input int i);
    return wide_t'(reg_file_out[i*DW +: DW]);
  endfunction

  task automatic model_accept(input logic [15:0] ins);
    exp_t          e;
    logic [2:0]    rx;
    logic [2:0]    ry;
    logic [1:0]    fmt;
    logic          imm;
    logic          legal;
    logic [DW-1:0] b;
    rx    = ins[15:13];
    ry    = ins[12:10];
    fmt   = ins[1:0];
    imm   = IMM && (fmt == 2'b01);
    legal = (fmt == 2'b00) || imm;
    b     = imm ? DW'(ins[12:5]) : m_rf[ry];
    e.c   = ref_alu(ins[4:2], m_rf[rx], b);
    e.ill = !legal;
    if (legal) m_rf[rx] = e.c;
    e.rf  = flat();
    e.acc = cyc;
    sbq.push_back(e);
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] v);
    dut.r_rf[idx] <= v;
    m_rf[idx] = v;
  endtask

  task automatic issue(input logic [15:0] ins, input bit hold);
    int n = 0;
    @(negedge clk);
    bif.inst_valid = 1'b1;
    while (!bif.inst_ready && n < 20) begin
      bif.instruction = 16'($urandom);
      @(negedge clk);
      n++;
    end
    if (!bif.inst_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: inst_ready=0 after %0d cycles, expected 1", n);
      bif.inst_valid = hold;
    end else begin
      bif.instruction = ins;
      model_accept(ins);
      last_acc = cyc;
      @(posedge clk);
      #1;
      bif.inst_valid  = hold;
      bif.instruction = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sbq.size() != 0 || !bif.inst_ready) && n < 40);
    if (sbq.size() != 0 || !bif.inst_ready) begin
      n_chk++;
      $display("FAIL idle_timeout: %0d outstanding after %0d cycles, expected 0", sbq.size(), n);
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (reset && bif.done) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_done: done=1 with nothing outstanding, expected 0");
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_regfile", reg_file_out, mon_e.rf);
        chk("sb_illegal", wide_t'(bif.illegal), wide_t'(mon_e.ill));
        chk("sb_latency", wide_t'(cyc - mon_e.acc), wide_t'(4));
        if (!mon_e.ill) chk("sb_c", wide_t'(reg_c_out), wide_t'(mon_e.c));
      end
    end
  end

  initial begin
    int    prev;
    int    dcount;
    wide_t snap;
    logic [1:0] fmt;
    bif.inst_valid  = 1'b0;
    bif.instruction = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_regfile", reg_file_out, '0);
    chk("rst_ready", wide_t'(bif.inst_ready), wide_t'(1));
    chk("rst_done", wide_t'(bif.done), wide_t'(0));
    chk("rst_illegal", wide_t'(bif.illegal), wide_t'(0));
    chk("rst_sci", wide_t'({reg_s_out, reg_c_out, reg_inst_out}), '0);
    reset = 1'b1;

    // reset asserted while the instruction sits in EXEC
    @(negedge clk);
    preload(1, 16'd5);
    preload(2, 16'd3);
    issue(mk(3'd1, 3'd2, 3'd0, 2'd0), 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_regfile", reg_file_out, '0);
    chk("midrst_ready", wide_t'(bif.inst_ready), wide_t'(1));
    chk("midrst_pulses", wide_t'({bif.done, bif.illegal}), '0);
    chk("midrst_sci", wide_t'({reg_s_out, reg_c_out, reg_inst_out}), '0);
    sbq.delete();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      dcount += int'(bif.done);
    end
    chk("midrst_no_done", wide_t'(dcount), '0);

    // add / sub / cmp chain
    preload(1, 16'd5);
    preload(2, 16'd3);
    issue(mk(3'd1, 3'd2, 3'd0, 2'd0), 1'b0);
    wait_idle();
    chk("add_r1", reg_of(1), wide_t'(8));
    issue(mk(3'd1, 3'd2, 3'd1, 2'd0), 1'b0);
    wait_idle();
    chk("sub_r1", reg_of(1), wide_t'(5));
    issue(mk(3'd1, 3'd2, 3'd7, 2'd0), 1'b0);
    wait_idle();
    chk("cmp_r1", reg_of(1), wide_t'(1));

    // wrap and shift-amount truncation
    preload(1, 16'hFFFF);
    preload(2, 16'd1);
    issue(mk(3'd1, 3'd2, 3'd0, 2'd0), 1'b0);
    wait_idle();
    chk("add_wrap", reg_of(1), wide_t'(0));
    preload(1, 16'd1);
    preload(2, 16'h0013);
    issue(mk(3'd1, 3'd2, 3'd5, 2'd0), 1'b0);
    wait_idle();
    chk("shl_r1", reg_of(1), wide_t'(16'h0008));

    // valid held high: one acceptance every 4 cycles, bus churn while busy is ignored
    for (int i = 0; i < 8; i++) preload(i, 16'($urandom));
    issue(mk(3'($urandom), 3'($urandom), 3'($urandom), 2'd0), 1'b1);
    prev = last_acc;
    issue(mk(3'($urandom), 3'($urandom), 3'($urandom), 2'd0), 1'b1);
    chk("interval_1", wide_t'(last_acc - prev), wide_t'(4));
    prev = last_acc;
    issue(mk(3'($urandom), 3'($urandom), 3'($urandom), 2'd0), 1'b0);
    chk("interval_2", wide_t'(last_acc - prev), wide_t'(4));
    wait_idle();

    // illegal formats leave the register file untouched
    snap = flat();
    issue(mk(3'd4, 3'd5, 3'd0, 2'b11), 1'b0);
    wait_idle();
    chk("fmt11_regfile", reg_file_out, snap);
    issue(mk(3'd4, 3'd5, 3'd4, 2'b10), 1'b0);
    wait_idle();
    chk("fmt10_regfile", reg_file_out, snap);
`ifdef BITTY_IMM_EN
    preload(3, 16'd10);
    issue({3'd3, 8'hF0, 3'd3, 2'b01}, 1'b0);
    wait_idle();
    chk("imm_or_r3", reg_of(3), wide_t'(16'h00FA));
`else
    issue(mk(3'd4, 3'd5, 3'd0, 2'b01), 1'b0);
    wait_idle();
    chk("fmt01_regfile", reg_file_out, snap);
`endif

    // randomized stream
    for (int k = 0; k < 200; k++) begin
      if (k % 50 == 0) begin
        bif.inst_valid = 1'b0;
        wait_idle();
        for (int i = 0; i < 8; i++) preload(i, 16'($urandom));
      end
      fmt = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom);
      issue({16'($urandom) & 16'hFFFC} | {14'b0, fmt}, 1'($urandom));
    end
    bif.inst_valid = 1'b0;
    wait_idle();
    chk("final_regfile", reg_file_out, flat());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
